// File: rtl/pdc_pkg.sv
// Shared types and helpers for the path delay checker: lane state, event record,
// default counter width and the saturating increment used by every lane.
package pdc_pkg;

  localparam int unsigned CW_DEF = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    TIMING = 1'b1
  } lane_state_t;

  // Record is sized for the default counter width.
  typedef struct packed {
    logic [CW_DEF-1:0] delay;
    logic              late;
    logic              spur;
  } ev_rec_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned cw);
    logic [31:0] max_v;
    max_v = (cw >= 32) ? '1 : ((32'd1 << cw) - 32'd1);
    return (cnt >= max_v) ? max_v : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/path_delay_checker_if.sv
// Event drain channel: the checker presents one measured event per handshake.
interface path_delay_checker_if #(
  parameter int unsigned NOUT = 3,
  parameter int unsigned CW   = pdc_pkg::CW_DEF
) ();
  localparam int unsigned IW = (NOUT > 1) ? $clog2(NOUT) : 1;

  logic          ev_valid;
  logic          ev_ready;
  logic [IW-1:0] ev_idx;
  logic [CW-1:0] ev_delay;
  logic          ev_late;
  logic          ev_spur;

  modport master (output ev_valid, ev_idx, ev_delay, ev_late, ev_spur, input ev_ready);
  modport slave  (input ev_valid, ev_idx, ev_delay, ev_late, ev_spur, output ev_ready);
endinterface

// File: rtl/pdc_lane.sv
// One measurement lane: times stimulus-to-response latency for a single response
// bit and holds at most one pending event, flagging drops as overflow.
module pdc_lane
  import pdc_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stim_chg_i,
  input  logic          resp_chg_i,
  input  logic [CW-1:0] limit_i,
  input  logic          accept_i,
  output logic          pending_o,
  output ev_rec_t       rec_o,
  output logic          ovf_o
);

  lane_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  ev_rec_t       rec_q, rec_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] delay;

  // NOTE: every variable gets its default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    rec_d     = rec_q;
    ovf_d     = ovf_q;
    delay     = '0;

    if (stim_chg_i) begin
      state_d = TIMING;
      cnt_d   = CW'(1);
    end else if (state_q == TIMING) begin
      cnt_d = CW'(sat_inc(32'(cnt_q), CW));
    end

    if (!stim_chg_i && state_q == TIMING) delay = cnt_q;

    if (accept_i) pending_d = 1'b0;

    // A change arriving while the slot is occupied and not draining is dropped.
    if (resp_chg_i) begin
      if (pending_q && !accept_i) begin
        ovf_d = 1'b1;
      end else begin
        pending_d   = 1'b1;
        rec_d.delay = CW_DEF'(delay);
        rec_d.late  = (delay > limit_i);
        rec_d.spur  = !stim_chg_i && (state_q == IDLE);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      rec_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      rec_q     <= rec_d;
      ovf_q     <= ovf_d;
    end
  end

  assign pending_o = pending_q;
  assign rec_o     = rec_q;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/path_delay_checker.sv
// Path delay checker top: change detection against the previous sample, one lane
// per response bit, and a lowest-index arbiter that locks its choice while stalled.
module path_delay_checker
  import pdc_pkg::*;
#(
  parameter int unsigned NIN  = 3,
  parameter int unsigned NOUT = 3,
  parameter int unsigned CW   = CW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NIN-1:0]     stim,
  input  logic [NOUT-1:0]    resp,
  input  logic [NOUT*CW-1:0] limits,
  path_delay_checker_if.master ev,
  output logic [NOUT-1:0]    viol,
  output logic [NOUT-1:0]    ovf
);

  localparam int unsigned IW = (NOUT > 1) ? $clog2(NOUT) : 1;

  logic            primed_q;
  logic [NIN-1:0]  stim_prev_q;
  logic [NOUT-1:0] resp_prev_q;
  logic            stim_chg;
  logic [NOUT-1:0] resp_chg;

  logic [NOUT-1:0] pending, accept, flagged;
  ev_rec_t         recs [NOUT];
  logic            ev_valid;
  logic [IW-1:0]   low_idx, cur_idx;
  logic            lock_q, lock_d;
  logic [IW-1:0]   lock_idx_q, lock_idx_d;
  logic [NOUT-1:0] viol_q, viol_d;

  // Nothing counts as a change until the first sample after reset has been taken.
  assign stim_chg = primed_q && (stim != stim_prev_q);
  assign resp_chg = {NOUT{primed_q}} & (resp ^ resp_prev_q);

  for (genvar g = 0; g < NOUT; g++) begin : g_lane
    pdc_lane #(.CW(CW)) u_lane (
      .clk        (clk),
      .reset      (reset),
      .stim_chg_i (stim_chg),
      .resp_chg_i (resp_chg[g]),
      .limit_i    (limits[g*CW +: CW]),
      .accept_i   (accept[g]),
      .pending_o  (pending[g]),
      .rec_o      (recs[g]),
      .ovf_o      (ovf[g])
    );
  end

  assign ev_valid = |pending;

  always_comb begin
    low_idx = '0;
    for (int k = NOUT - 1; k >= 0; k--) begin
      if (pending[k]) low_idx = IW'(k);
    end
    cur_idx = lock_q ? lock_idx_q : low_idx;

    accept = '0;
    if (ev_valid && ev.ev_ready) accept[cur_idx] = 1'b1;

    for (int k = 0; k < NOUT; k++) flagged[k] = recs[k].late | recs[k].spur;
    viol_d = viol_q | (accept & flagged);

    lock_d     = ev_valid && !ev.ev_ready;
    lock_idx_d = cur_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      primed_q    <= 1'b0;
      stim_prev_q <= '0;
      resp_prev_q <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      viol_q      <= '0;
    end else begin
      primed_q    <= 1'b1;
      stim_prev_q <= stim;
      resp_prev_q <= resp;
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
      viol_q      <= viol_d;
    end
  end

  assign ev.ev_valid = ev_valid;
  assign ev.ev_idx   = cur_idx;
  assign ev.ev_delay = CW'(recs[cur_idx].delay);
  assign ev.ev_late  = recs[cur_idx].late;
  assign ev.ev_spur  = recs[cur_idx].spur;
  assign viol        = viol_q;

endmodule

// File: tb/tb_path_delay_checker.sv
// Directed bench for path_delay_checker: delay, late, spurious, stall arbitration,
// overflow, saturation and mid-operation reset, all with hand-computed expectations.
module tb_path_delay_checker;

  localparam int unsigned NIN  = 3;
  localparam int unsigned NOUT = 3;
  localparam int unsigned CW   = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic [NIN-1:0]     stim;
  logic [NOUT-1:0]    resp;
  logic [NOUT*CW-1:0] limits;
  logic [NOUT-1:0]    viol, ovf;

  int n_tests = 0;
  int n_fail  = 0;

  path_delay_checker_if #(.NOUT(NOUT), .CW(CW)) ev_if ();

  path_delay_checker #(.NIN(NIN), .NOUT(NOUT), .CW(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .stim   (stim),
    .resp   (resp),
    .limits (limits),
    .ev     (ev_if),
    .viol   (viol),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_ev(input string tag, input int idx, input int delay,
                          input bit late, input bit spur);
    check({tag, "_valid"}, 32'(ev_if.ev_valid), 32'd1);
    check({tag, "_idx"},   32'(ev_if.ev_idx),   32'(idx));
    check({tag, "_delay"}, 32'(ev_if.ev_delay), 32'(delay));
    check({tag, "_late"},  32'(ev_if.ev_late),  32'(late));
    check({tag, "_spur"},  32'(ev_if.ev_spur),  32'(spur));
  endtask

  initial begin
    limits         = {8'd23, 8'd11, 8'd12};
    reset          = 1'b1;
    stim           = 3'b000;
    resp           = 3'b000;
    ev_if.ev_ready = 1'b1;
    tick(2);
    check("rst_valid", 32'(ev_if.ev_valid), 32'd0);
    check("rst_viol",  32'(viol), 32'd0);
    check("rst_ovf",   32'(ovf),  32'd0);

    reset = 1'b0;
    tick();                              // priming edge

    // Basic delay: resp[0] 12 cycles after the stimulus change.
    stim = 3'b011; tick();
    tick(11);
    resp[0] = ~resp[0]; tick();
    check_ev("basic", 0, 12, 1'b0, 1'b0);
    tick();
    check("basic_drained", 32'(ev_if.ev_valid), 32'd0);
    check("basic_viol", 32'(viol), 32'd0);

    // Late: resp[1] 16 cycles after a change, limit 11.
    stim = 3'b110; tick();
    tick(15);
    resp[1] = ~resp[1]; tick();
    check_ev("late", 1, 16, 1'b1, 1'b0);
    tick();
    check("late_viol", 32'(viol), 32'b010);

    // Spurious: fresh reset leaves lanes idle.
    reset = 1'b1; tick(2);
    reset = 1'b0; tick();
    resp[2] = ~resp[2]; tick();
    check_ev("spur", 2, 0, 1'b0, 1'b1);
    tick();
    check("spur_viol", 32'(viol), 32'b100);

    // Same-cycle stimulus and response change.
    stim = 3'b001; resp[2] = ~resp[2]; tick();
    check_ev("same", 2, 0, 1'b0, 1'b0);
    tick();

    // Stall: lane 2 at +5, lane 0 at +8; lane 2 stays presented.
    ev_if.ev_ready = 1'b0;
    stim = 3'b101; tick();
    tick(4);
    resp[2] = ~resp[2]; tick();
    check_ev("stall_a", 2, 5, 1'b0, 1'b0);
    tick(2);
    resp[0] = ~resp[0]; tick();
    check_ev("stall_b", 2, 5, 1'b0, 1'b0);
    ev_if.ev_ready = 1'b1; tick();
    check_ev("stall_next", 0, 8, 1'b0, 1'b0);
    tick();
    check("stall_drained", 32'(ev_if.ev_valid), 32'd0);
    check("stall_viol", 32'(viol), 32'b100);

    // Overflow: two resp[1] toggles while stalled.
    ev_if.ev_ready = 1'b0;
    stim = 3'b100; tick();
    tick(2);
    resp[1] = ~resp[1]; tick();
    resp[1] = ~resp[1]; tick();
    check("ovf_flag", 32'(ovf), 32'b010);
    check_ev("ovf_kept", 1, 3, 1'b0, 1'b0);
    ev_if.ev_ready = 1'b1; tick();
    check("ovf_drained", 32'(ev_if.ev_valid), 32'd0);

    // Saturation: long quiet period then resp[0].
    tick(300);
    resp[0] = ~resp[0]; tick();
    check_ev("sat", 0, 255, 1'b1, 1'b0);
    tick();
    check("sat_viol", 32'(viol), 32'b101);

    // Reset with two events pending.
    ev_if.ev_ready = 1'b0;
    resp[0] = ~resp[0]; resp[1] = ~resp[1]; tick();
    check("mid_pending", 32'(ev_if.ev_valid), 32'd1);
    reset = 1'b1; tick();
    check("mid_valid", 32'(ev_if.ev_valid), 32'd0);
    check("mid_viol",  32'(viol), 32'd0);
    check("mid_ovf",   32'(ovf),  32'd0);
    ev_if.ev_ready = 1'b1;
    reset = 1'b0; resp[2] = ~resp[2]; tick();
    tick();
    check("mid_noev", 32'(ev_if.ev_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/path_delay_checker.md
Name: path_delay_checker

Overview:
- Synchronous monitor that measures, in clock cycles, the latency from each change of a stimulus vector to each subsequent change on every bit of a response vector.
- Each response change is reported as an event with its measured delay, compared against a per-output limit.
- Sits in simulation and regression harnesses on the observing side of a device under test, opposite the stimulus generator that drives input vectors.
- Events are queued per output and drained over a valid/ready interface.

Parameters:
- NIN, 3: stimulus vector width.
- NOUT, 3: response vector width; one measurement lane per bit.
- CW, 8: delay counter and limit width; counters saturate at 2^CW-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stim  in  NIN  sampled stimulus vector.
- resp  in  NOUT  sampled response vector.
- limits  in  NOUT*CW  per-lane maximum allowed delay; lane k occupies bits [k*CW +: CW].
- ev_valid  out  1  an event is presented.
- ev_ready  in  1  consumer accepts the event when ev_valid & ev_ready.
- ev_idx  out  clog2(NOUT) (min 1)  lane number of the presented event.
- ev_delay  out  CW  measured delay of the presented event.
- ev_late  out  1  ev_delay > limit of that lane.
- ev_spur  out  1  response changed with no preceding stimulus change.
- viol  out  NOUT  sticky per lane: set on any reported late or spurious event.
- ovf  out  NOUT  sticky per lane: a response change was dropped because the lane was still pending.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs are 0.
  - All lanes are IDLE with count 0, no pending event and primed = 0.
- First cycle after reset: stim and resp are copied into prev registers and primed is set. No change is detected in that cycle.
- Change detection (primed = 1 only):
  - stim_chg = (stim != stim_prev).
  - resp_chg[k] = (resp[k] != resp_prev[k]).
  - prev registers update every cycle.
- Lane states:
  - IDLE: before the first stim_chg.
  - TIMING: after any stim_chg; remains TIMING until reset.
- On stim_chg: every lane enters TIMING and its count loads 1 for the next cycle. If there is no stim_chg, a TIMING lane's count increments and saturates at 2^CW-1; the count holds at saturation.
- Delay recorded on resp_chg[k]:
  - Same cycle as stim_chg: delay 0 (the new stimulus owns it).
  - TIMING without stim_chg: delay = current count.
  - IDLE: delay 0 with spur = 1.
  - late = (delay > limits[k]), computed from the limit in the capture cycle.
- Pending and overflow:
  - Capture sets pending[k] and stores delay, late and spur.
  - If pending[k] is already set and not being accepted this cycle, the new change is dropped and ovf[k] sets; stored data is unchanged.
  - If the pending event is accepted in the same cycle as a new capture, the new one is stored and there is no overflow.
- Output arbitration:
  - ev_valid = |pending.
  - The presented lane is the lowest-index pending lane, locked while ev_valid & !ev_ready. A lower-index capture during a stall does not preempt the presented lane.
  - ev_* outputs are registered and stable while stalled.
  - On accept, that lane's pending clears. The next lane is presented the following cycle, giving one event per cycle of throughput.
  - viol[k] sets on acceptance of a late or spur event.
- Reset mid-operation discards all pending events and sticky flags, then re-primes.
- A single stim_chg restarts all lanes regardless of which stimulus bit changed.

Decomposition:
- Package pdc_pkg:
  - lane_state_t enum {IDLE, TIMING}.
  - Default CW.
  - Helper function sat_inc(count).
  - Event record struct {delay, late, spur}.
- Sub-module pdc_lane, one instance per response bit, containing:
  - lane state and saturating counter;
  - capture and pending registers;
  - overflow flag logic.
- The top level holds:
  - prev/primed registers;
  - lowest-index lock-on-stall arbiter;
  - event output registers;
  - viol flags.

Test Plan (NIN=3, NOUT=3, CW=8, limits = {23, 11, 12} for lanes 2, 1, 0):
- Basic delay: stim 000->011 at cycle t, resp[0] toggles at t+12, ev_ready = 1 -> one event {idx 0, delay 12, late 0, spur 0}; viol = 000.
- Late: same stimulus, resp[1] toggles at t+16 -> {idx 1, delay 16, late 1}; after accept, viol = 010.
- Spurious and same-cycle: resp[2] toggles before any stim change -> {idx 2, delay 0, spur 1}. Then stim and resp[2] change in the same cycle -> {delay 0, spur 0}.
- Stall and arbitration:
  - Hold ev_ready = 0; resp[2] changes at t+5, then resp[0] at t+8.
  - Lane 2 is presented and stays stable with delay 5.
  - Raise ev_ready -> lane 2 accepted, then lane 0 with delay 8 on the next cycle.
- Overflow and saturation:
  - Toggle resp[1] twice while stalled -> ovf = 010; first event preserved.
  - With no stim change for 300 cycles, then a resp[0] toggle -> delay 255, late 1.
- Reset mid-operation: reset while two events are pending -> ev_valid = 0 and viol/ovf cleared next cycle; a resp toggle in the first post-reset cycle produces no event.
